sprite_layer_compositor: RTL and testbench

//  Pipelined N-layer sprite compositor for the VGA path; generalises the fixed two-fighter color mapper.
//  Per pixel: hit-tests every layer rectangle and generates each layer's sprite-ROM address (optional H-flip).

---
 rtl/sprite_layer_compositor.sv | 155 +++++++++++++++
 tb/tb_sprite_layer_compositor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer_compositor.sv
// N-layer sprite compositor: hit-test + ROM addressing, then priority/transparency merge.
// Optional COMPOSITOR_COLLISION_EN adds per-frame layer collision flags.
module sprite_layer_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int COORD_W    = 10,
    parameter int ADDR_W     = 19,
    parameter int COLOR_W    = 8,
    parameter int ROM_LAT    = 1
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            pix_valid,
    input  logic                            frame_start,
    input  logic [COORD_W-1:0]              DrawX,
    input  logic [COORD_W-1:0]              DrawY,
    input  logic [NUM_LAYERS-1:0]           layer_en,
    input  logic [NUM_LAYERS-1:0]           layer_flip,
    input  logic [NUM_LAYERS*COORD_W-1:0]   layer_x,
    input  logic [NUM_LAYERS*COORD_W-1:0]   layer_y,
    input  logic [NUM_LAYERS*COORD_W-1:0]   layer_w,
    input  logic [NUM_LAYERS*COORD_W-1:0]   layer_h,
    input  logic [NUM_LAYERS*ADDR_W-1:0]    layer_base,
    output logic [NUM_LAYERS*ADDR_W-1:0]    rom_addr,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] rom_rgb,
    input  logic [NUM_LAYERS-1:0]           rom_zero,
    input  logic [3*COLOR_W-1:0]            bg_rgb,
    output logic                            out_valid,
    output logic [COLOR_W-1:0]              VGA_R,
    output logic [COLOR_W-1:0]              VGA_G,
    output logic [COLOR_W-1:0]              VGA_B,
    output logic [NUM_LAYERS-1:0]           collide_flags
);

    localparam int CW1   = COORD_W + 1;
    localparam int PW    = 2 * CW1;
    localparam int RGB_W = 3 * COLOR_W;

    logic [NUM_LAYERS*ADDR_W-1:0] addr_d, addr_q;
    logic [NUM_LAYERS-1:0]        hit_d, hit_q;
    logic                         vld_q;
    logic [NUM_LAYERS-1:0]        hit_dl_q [ROM_LAT];
    logic                         vld_dl_q [ROM_LAT];
    logic [NUM_LAYERS-1:0]        hit_a, opaque;
    logic                         vld_a;
    logic [RGB_W-1:0]             rgb_sel, rgb_d, rgb_q;
    logic                         out_valid_q;

    // Differences are one bit wider than coordinates so clipped sprites never wrap.
    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
        logic [COORD_W-1:0] lx, ly, lw, lh;
        logic [CW1-1:0]     dx, dy, col;
        logic [ADDR_W-1:0]  a;
        assign lx  = layer_x[g*COORD_W +: COORD_W];
        assign ly  = layer_y[g*COORD_W +: COORD_W];
        assign lw  = layer_w[g*COORD_W +: COORD_W];
        assign lh  = layer_h[g*COORD_W +: COORD_W];
        assign dx  = {1'b0, DrawX} - {1'b0, lx};
        assign dy  = {1'b0, DrawY} - {1'b0, ly};
        assign col = layer_flip[g] ? ({1'b0, lw} - CW1'(1) - dx) : dx;
        assign a   = layer_base[g*ADDR_W +: ADDR_W]
                   + ADDR_W'(PW'(dy) * PW'(lw))
                   + ADDR_W'(col);
        assign hit_d[g] = layer_en[g] & pix_valid
                        & (DrawX >= lx) & (dx < {1'b0, lw})
                        & (DrawY >= ly) & (dy < {1'b0, lh});
        assign addr_d[g*ADDR_W +: ADDR_W] = hit_d[g] ? a : '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q <= '0;
            hit_q  <= '0;
            vld_q  <= 1'b0;
            for (int k = 0; k < ROM_LAT; k++) begin
                hit_dl_q[k] <= '0;
                vld_dl_q[k] <= 1'b0;
            end
            rgb_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            hit_q       <= hit_d;
            vld_q       <= pix_valid;
            hit_dl_q[0] <= hit_q;
            vld_dl_q[0] <= vld_q;
            for (int k = 1; k < ROM_LAT; k++) begin
                hit_dl_q[k] <= hit_dl_q[k-1];
                vld_dl_q[k] <= vld_dl_q[k-1];
            end
            rgb_q       <= rgb_d;
            out_valid_q <= vld_a;
        end
    end

    assign hit_a  = hit_dl_q[ROM_LAT-1];
    assign vld_a  = vld_dl_q[ROM_LAT-1];
    assign opaque = hit_a & ~rom_zero;

    // Walk from lowest priority up so layer 0 wins.
    always_comb begin
        rgb_sel = bg_rgb;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) rgb_sel = rom_rgb[i*RGB_W +: RGB_W];
        end
        rgb_d = vld_a ? rgb_sel : '0;
    end

`ifdef COMPOSITOR_COLLISION_EN
    logic                  fs_q;
    logic                  fs_dl_q [ROM_LAT];
    logic                  fs_a;
    logic [NUM_LAYERS-1:0] live_d, live_q, coll_q;

    always_comb begin
        live_d = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            live_d[i] = opaque[i] & |(opaque & ~(NUM_LAYERS'(1) << i));
        end
    end

    assign fs_a = fs_dl_q[ROM_LAT-1];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fs_q <= 1'b0;
            for (int k = 0; k < ROM_LAT; k++) fs_dl_q[k] <= 1'b0;
            live_q <= '0;
            coll_q <= '0;
        end else begin
            fs_q       <= frame_start & pix_valid;
            fs_dl_q[0] <= fs_q;
            for (int k = 1; k < ROM_LAT; k++) fs_dl_q[k] <= fs_dl_q[k-1];
            if (fs_a) begin
                coll_q <= live_q;
                live_q <= live_d;
            end else begin
                live_q <= live_q | live_d;
            end
        end
    end

    assign collide_flags = coll_q;
`else
    logic unused_fs;
    assign unused_fs     = frame_start;
    assign collide_flags = '0;
`endif

    assign rom_addr  = addr_q;
    assign out_valid = out_valid_q;
    assign VGA_R     = rgb_q[2*COLOR_W +: COLOR_W];
    assign VGA_G     = rgb_q[COLOR_W +: COLOR_W];
    assign VGA_B     = rgb_q[0 +: COLOR_W];

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Directed bench for sprite_layer_compositor with a 1-cycle sprite-ROM model.
module tb_sprite_layer_compositor;

    localparam int N   = 4;
    localparam int CW  = 10;
    localparam int AW  = 19;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pix_valid, frame_start;
    logic [CW-1:0]     DrawX, DrawY;
    logic [N-1:0]      layer_en, layer_flip;
    logic [N*CW-1:0]   layer_x, layer_y, layer_w, layer_h;
    logic [N*AW-1:0]   layer_base, rom_addr;
    logic [N*24-1:0]   rom_rgb;
    logic [N-1:0]      rom_zero, zero_ctl, collide_flags;
    logic [23:0]       bg_rgb;
    logic              out_valid;
    logic [7:0]        VGA_R, VGA_G, VGA_B;

    logic [CW-1:0] lx [N], ly [N], lw [N], lh [N];
    logic [AW-1:0] lb [N];

    int ntest = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    sprite_layer_compositor dut (
        .Clk(clk), .Reset_n(rst_n), .pix_valid(pix_valid),
        .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
        .layer_en(layer_en), .layer_flip(layer_flip),
        .layer_x(layer_x), .layer_y(layer_y),
        .layer_w(layer_w), .layer_h(layer_h),
        .layer_base(layer_base), .rom_addr(rom_addr),
        .rom_rgb(rom_rgb), .rom_zero(rom_zero), .bg_rgb(bg_rgb),
        .out_valid(out_valid), .VGA_R(VGA_R), .VGA_G(VGA_G),
        .VGA_B(VGA_B), .collide_flags(collide_flags)
    );

    always_comb begin
        layer_x = '0; layer_y = '0; layer_w = '0; layer_h = '0;
        layer_base = '0;
        for (int i = 0; i < N; i++) begin
            layer_x[i*CW +: CW]    = lx[i];
            layer_y[i*CW +: CW]    = ly[i];
            layer_w[i*CW +: CW]    = lw[i];
            layer_h[i*CW +: CW]    = lh[i];
            layer_base[i*AW +: AW] = lb[i];
        end
    end

    // Sprite ROM: colour = {addr[7:0], layer tag, A5}, one cycle latency.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            rom_rgb[i*24 +: 24] <= {rom_addr[i*AW +: 8], 8'((i + 1) * 17), 8'hA5};
        end
        rom_zero <= zero_ctl;
    end

    function automatic logic [23:0] rgb_of(int l, int a);
        return {8'(a), 8'((l + 1) * 17), 8'hA5};
    endfunction

    function automatic logic [AW-1:0] addr_of(int l);
        return rom_addr[l*AW +: AW];
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        ntest++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_layers();
        layer_en = '0; layer_flip = '0; zero_ctl = '0;
        for (int i = 0; i < N; i++) begin
            lx[i] = '0; ly[i] = '0; lw[i] = '0; lh[i] = '0; lb[i] = '0;
        end
    endtask

    task automatic drive(int x, int y, bit fs, int n);
        @(negedge clk);
        DrawX = CW'(x); DrawY = CW'(y);
        pix_valid = 1'b1; frame_start = fs;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic show(int x, int y);
        drive(x, y, 1'b0, LAT);
    endtask

    function automatic logic [23:0] vga();
        return {VGA_R, VGA_G, VGA_B};
    endfunction

    initial begin
        int first;
        rst_n = 1'b1; pix_valid = 1'b0; frame_start = 1'b0;
        DrawX = '0; DrawY = '0; bg_rgb = 24'h102030;
        clr_layers();
        #2 rst_n = 1'b0;

        // T1: reset during live pixels, then release latency
        layer_en[0] = 1'b1; lx[0] = 100; ly[0] = 50; lw[0] = 100; lh[0] = 100;
        DrawX = 150; DrawY = 60; pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_addr", 32'(addr_of(0)), 0);
        check("rst_rgb", 32'(vga()), 0);
        check("rst_coll", 32'(collide_flags), 0);
        rst_n = 1'b1;
        first = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (out_valid && first == 0) first = n;
        end
        check("latency", 32'(first), LAT);
        check("t1_rgb", 32'(vga()), 32'(rgb_of(0, 1050)));

        // T2: streaming row across the sprite
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            if (k > 0) check("t2_addr", 32'(addr_of(0)), 32'(1000 + k - 1));
            DrawX = CW'(100 + k);
        end
        @(negedge clk);
        check("t2_addr200", 32'(addr_of(0)), 0);
        show(200, 60);
        check("t2_bg", 32'(vga()), 32'h102030);
        show(150, 60);
        check("t2_rgb150", 32'(vga()), 32'(rgb_of(0, 1050)));

        // T3: horizontal flip
        layer_flip[0] = 1'b1;
        show(100, 60);
        check("t3_addr100", 32'(addr_of(0)), 1099);
        check("t3_rgb100", 32'(vga()), 32'(rgb_of(0, 1099)));
        show(199, 60);
        check("t3_addr199", 32'(addr_of(0)), 1000);

        // T4: priority and transparency; L1 has w=0
        clr_layers();
        layer_en = 4'b0111;
        lx[0] = 300; ly[0] = 200; lw[0] = 50; lh[0] = 50;
        lx[1] = 300; ly[1] = 200; lw[1] = 0;  lh[1] = 50;
        lx[2] = 300; ly[2] = 200; lw[2] = 50; lh[2] = 50; lb[2] = 5000;
        show(310, 205);
        check("t4_a0", 32'(addr_of(0)), 260);
        check("t4_a1_w0", 32'(addr_of(1)), 0);
        check("t4_a2", 32'(addr_of(2)), 5260);
        check("t4_l0", 32'(vga()), 32'h0411A5);
        zero_ctl = 4'b0001;
        show(310, 205);
        check("t4_l2", 32'(vga()), 32'h8C33A5);
        zero_ctl = 4'b0101;
        show(310, 205);
        check("t4_bg", 32'(vga()), 32'h102030);
        zero_ctl = 4'b0000;
        show(400, 205);
        check("t4_miss", 32'(vga()), 32'h102030);
        @(negedge clk);
        pix_valid = 1'b0;
        repeat (LAT) @(negedge clk);
        check("t4_blank_v", 32'(out_valid), 0);
        check("t4_blank_rgb", 32'(vga()), 0);

        // T5: right-edge clipping
        clr_layers();
        layer_en[0] = 1'b1; lx[0] = 1000; ly[0] = 0; lw[0] = 100; lh[0] = 10;
        show(0, 5);
        check("t5_x0", 32'(addr_of(0)), 0);
        check("t5_x0_bg", 32'(vga()), 32'h102030);
        show(23, 5);
        check("t5_x23", 32'(addr_of(0)), 0);
        show(1023, 5);
        check("t5_x1023", 32'(addr_of(0)), 523);
        check("t5_rgb", 32'(vga()), 32'(rgb_of(0, 523)));

        // T6: collision flags
        clr_layers();
        layer_en = 4'b0011;
        lx[0] = 300; ly[0] = 200; lw[0] = 50; lh[0] = 50;
        lx[1] = 300; ly[1] = 200; lw[1] = 50; lh[1] = 50; lb[1] = 3000;
        drive(0, 0, 1'b1, LAT + 1);
        show(300, 200);
        drive(0, 0, 1'b1, LAT + 1);
`ifdef COMPOSITOR_COLLISION_EN
        check("t6_coll", 32'(collide_flags), 32'h3);
        drive(0, 0, 1'b1, LAT + 1);
        check("t6_clear", 32'(collide_flags), 0);
`else
        check("t6_tied", 32'(collide_flags), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
